// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and types for the VGA raster timing block.
//   - Default 640x480@60 timing constants (horizontal in clocks, vertical in lines)
//   - vga_pos_t: packed pixel position (x, y), 10 bits each
//   - axis_total(): sum of visible + porches + sync for one axis
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;

    // Counters are 10 bits wide, so no axis may exceed this many positions.
    localparam int unsigned MAX_TOTAL = 1024;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } vga_pos_t;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk_i     pixel clock
//   rst_ni    asynchronous active-low reset
//   en_i      count enable (1 for horizontal, horizontal wrap for vertical)
//   count_o   current position, 0..Total-1
//   wrap_o    combinational: high on the cycle whose edge wraps the count to 0
//   active_o  registered: position is inside the visible region
//   sync_n_o  registered: active-low sync pulse
// Decodes are registered from the next-count value so they line up with count_o.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned Visible    = H_VISIBLE_DEF,
    parameter int unsigned FrontPorch = H_FP_DEF,
    parameter int unsigned SyncWidth  = H_SYNC_DEF,
    parameter int unsigned BackPorch  = H_BP_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [9:0] count_o,
    output logic       wrap_o,
    output logic       active_o,
    output logic       sync_n_o
);

    localparam int unsigned Total = axis_total(Visible, FrontPorch, SyncWidth, BackPorch);

    if (Total > MAX_TOTAL) begin : g_total_too_large
        $error("vga_axis_counter: axis total %0d exceeds %0d", Total, MAX_TOTAL);
    end

    // 11-bit compares so a sync window ending exactly at 1024 still decodes.
    localparam logic [10:0] LastCount = 11'(Total - 1);
    localparam logic [10:0] VisEnd    = 11'(Visible);
    localparam logic [10:0] SyncStart = 11'(Visible + FrontPorch);
    localparam logic [10:0] SyncEnd   = 11'(Visible + FrontPorch + SyncWidth);

    logic [9:0]  count_d, count_q;
    logic        active_d, active_q;
    logic        sync_n_d, sync_n_q;
    logic [10:0] count_ext;

    always_comb begin
        wrap_o  = en_i && ({1'b0, count_q} == LastCount);
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? 10'd0 : count_q + 10'd1;
        end
        count_ext = {1'b0, count_d};
        active_d  = count_ext < VisEnd;
        sync_n_d  = !((count_ext >= SyncStart) && (count_ext < SyncEnd));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 10'd0;
            active_q <= 1'b0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = active_q;
    assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source.
//   vga_clk      pixel clock (rising edge)
//   reset_n      asynchronous active-low reset
//   hs, vs       active-low horizontal / vertical sync
//   blank        1 = visible pixel, 0 = blanking
//   DrawX/DrawY  current raster position
//   line_start   high while DrawX == 0 (not for the first line after reset)
//   frame_start  high while DrawX == 0 and DrawY == 0 (not for the first frame)
//   frame_count  completed frames, modulo 256
// Build option VGA_ALIGN_EN: hs, vs and blank get one extra register stage so they
// lag DrawX/DrawY by one clock (matches renderers with a one-cycle color pipeline).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    logic [9:0] hc, vc;
    logic       h_wrap, v_wrap;
    logic       h_active, v_active;
    logic       h_sync_n, v_sync_n;
    vga_pos_t   pos;

    vga_axis_counter #(
        .Visible   (H_VISIBLE),
        .FrontPorch(H_FP),
        .SyncWidth (H_SYNC),
        .BackPorch (H_BP)
    ) u_h_axis (
        .clk_i   (vga_clk),
        .rst_ni  (reset_n),
        .en_i    (1'b1),
        .count_o (hc),
        .wrap_o  (h_wrap),
        .active_o(h_active),
        .sync_n_o(h_sync_n)
    );

    vga_axis_counter #(
        .Visible   (V_VISIBLE),
        .FrontPorch(V_FP),
        .SyncWidth (V_SYNC),
        .BackPorch (V_BP)
    ) u_v_axis (
        .clk_i   (vga_clk),
        .rst_ni  (reset_n),
        .en_i    (h_wrap),
        .count_o (vc),
        .wrap_o  (v_wrap),
        .active_o(v_active),
        .sync_n_o(v_sync_n)
    );

    logic       line_start_d, line_start_q;
    logic       frame_start_d, frame_start_q;
    logic [7:0] frame_count_d, frame_count_q;
    logic       hs_d, vs_d, blank_d;

    // The next count is 0 exactly when the axis wraps, so the wrap strobes are the
    // next-state of the position strobes. v_wrap is already qualified by h_wrap.
    always_comb begin
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
        frame_count_d = frame_count_q + (v_wrap ? 8'd1 : 8'd0);
        hs_d          = h_sync_n;
        vs_d          = v_sync_n;
        blank_d       = h_active && v_active;
        pos.x         = hc;
        pos.y         = vc;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef VGA_ALIGN_EN
    logic hs_q, vs_q, blank_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
        end
    end

    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`else
    assign hs    = hs_d;
    assign vs    = vs_d;
    assign blank = blank_d;
`endif

    assign DrawX       = pos.x;
    assign DrawY       = pos.y;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance for reset, line timing
// and mid-line reset, and a small-timing instance run for 300 frames against a model.
module tb_vga_timing_gen;

`ifdef VGA_ALIGN_EN
    localparam int Lag = 1;
`else
    localparam int Lag = 0;
`endif

    // {DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count}
    localparam logic [32:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    logic       clk;
    logic       rst_n, rst_s_n;
    logic       hs, vs, blank, line_start, frame_start;
    logic [9:0] DrawX, DrawY;
    logic [7:0] frame_count;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;
    logic [32:0] big_obs, small_obs;

    int checks = 0;
    int errors = 0;

    assign big_obs   = {DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count};
    assign small_obs = {s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc};

    vga_timing_gen dut (
        .vga_clk    (clk),
        .reset_n    (rst_n),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_small (
        .vga_clk    (clk),
        .reset_n    (rst_s_n),
        .hs         (s_hs),
        .vs         (s_vs),
        .blank      (s_blank),
        .DrawX      (s_x),
        .DrawY      (s_y),
        .line_start (s_ls),
        .frame_start(s_fs),
        .frame_count(s_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected small-instance outputs k edges after reset release (8 x 6 raster).
    function automatic logic [32:0] small_model(input int k);
        int m, hc, vc;
        logic hs_e, vs_e, bl_e, ls_e, fs_e;
        m = k - Lag;
        if (m <= 0) begin
            hs_e = 1'b1;
            vs_e = 1'b1;
            bl_e = 1'b0;
        end else begin
            hc   = m % 8;
            vc   = (m / 8) % 6;
            bl_e = (hc < 4) && (vc < 3);
            hs_e = (hc != 5);
            vs_e = (vc != 4);
        end
        ls_e = (k > 0) && (k % 8 == 0);
        fs_e = (k > 0) && (k % 48 == 0);
        return {10'(k % 8), 10'((k / 8) % 6), hs_e, vs_e, bl_e, ls_e, fs_e, 8'((k / 48) % 256)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (big_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", big_obs, RESET_VEC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (DrawX !== 10'd1 || DrawY !== 10'd0) begin
            errors++;
            $display("FAIL first_edge_pos: got (%0d,%0d) required (1,0)", DrawX, DrawY);
        end
        checks++;
        if (blank !== 1'(Lag == 0)) begin
            errors++;
            $display("FAIL first_edge_blank: got %b required %b", blank, Lag == 0);
        end
        checks++;
        if ({hs, vs} !== 2'b11) begin
            errors++;
            $display("FAIL first_edge_sync: got %b%b required 11", hs, vs);
        end
        checks++;
        if ({line_start, frame_start, frame_count} !== 10'd0) begin
            errors++;
            $display("FAIL first_edge_strobes: got %b %b %0d required 0 0 0",
                     line_start, frame_start, frame_count);
        end
    endtask

    // Runs edges 2..1600 after release: two full lines.
    task automatic test_line_timing();
        int pos_err = 0, hs_low = 0, vs_low = 0, ls_bad = 0;
        int first_ls = -1, second_ls = -1, first_hs_x = -1, blank_fall_x = -1;
        logic prev_blank;
        prev_blank = blank;
        for (int k = 2; k <= 1600; k++) begin
            @(negedge clk);
            if (DrawX !== 10'(k % 800) || DrawY !== 10'(k / 800)) pos_err++;
            if (line_start) begin
                if (DrawX !== 10'd0) ls_bad++;
                if (first_ls < 0) first_ls = k;
                else if (second_ls < 0) second_ls = k;
            end
            if (k < 800 && !hs) hs_low++;
            if (!hs && first_hs_x < 0) first_hs_x = int'(DrawX);
            if (prev_blank && !blank && blank_fall_x < 0) blank_fall_x = int'(DrawX);
            prev_blank = blank;
            if (!vs) vs_low++;
        end
        checks++;
        if (pos_err != 0) begin
            errors++;
            $display("FAIL line_position: got %0d bad cycles required 0", pos_err);
        end
        checks++;
        if (first_ls != 800 || second_ls != 1600) begin
            errors++;
            $display("FAIL line_start_period: got edges %0d,%0d required 800,1600",
                     first_ls, second_ls);
        end
        checks++;
        if (ls_bad != 0) begin
            errors++;
            $display("FAIL line_start_pos: got %0d off-zero pulses required 0", ls_bad);
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hs_width: got %0d required 96", hs_low);
        end
        checks++;
        if (first_hs_x != 656 + Lag) begin
            errors++;
            $display("FAIL hs_start: got DrawX %0d required %0d", first_hs_x, 656 + Lag);
        end
        checks++;
        if (blank_fall_x != 640 + Lag) begin
            errors++;
            $display("FAIL blank_fall: got DrawX %0d required %0d", blank_fall_x, 640 + Lag);
        end
        checks++;
        if (vs_low != 0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL early_lines_vs: got vs_low %0d fc %0d required 0 0",
                     vs_low, frame_count);
        end
    endtask

    // Edge 1900 puts the raster at (300, 2); reset there asynchronously.
    task automatic test_mid_reset();
        repeat (300) @(negedge clk);
        checks++;
        if (DrawX !== 10'd300 || DrawY !== 10'd2 || blank !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pos: got (%0d,%0d) blank %b required (300,2) blank 1",
                     DrawX, DrawY, blank);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (big_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", big_obs, RESET_VEC);
        end
        @(negedge clk);
        checks++;
        if (big_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %h required %h", big_obs, RESET_VEC);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (DrawX !== 10'd3 || DrawY !== 10'd0 || blank !== 1'b1 || line_start !== 1'b0) begin
            errors++;
            $display("FAIL restart: got (%0d,%0d) blank %b ls %b required (3,0) 1 0",
                     DrawX, DrawY, blank, line_start);
        end
    endtask

    // 300 frames of the 8 x 6 raster, checked against the model every cycle.
    task automatic test_small_frames();
        int fs_count = 0;
        logic wrap_seen = 1'b0;
        logic [7:0] prev_fc;
        logic [32:0] exp;
        rst_s_n = 1'b0;
        @(negedge clk);
        checks++;
        if (small_obs !== RESET_VEC) begin
            errors++;
            $display("FAIL small_reset: got %h required %h", small_obs, RESET_VEC);
        end
        rst_s_n = 1'b1;
        prev_fc = s_fc;
        for (int k = 1; k <= 14400; k++) begin
            @(negedge clk);
            exp = small_model(k);
            checks++;
            if (small_obs !== exp) begin
                errors++;
                $display("FAIL small_model edge %0d: got %h required %h", k, small_obs, exp);
            end
            if (s_fs) fs_count++;
            if (prev_fc == 8'd255 && s_fc == 8'd0) wrap_seen = 1'b1;
            prev_fc = s_fc;
        end
        checks++;
        if (fs_count != 300) begin
            errors++;
            $display("FAIL small_frame_starts: got %0d required 300", fs_count);
        end
        checks++;
        if (!wrap_seen || s_fc !== 8'd44) begin
            errors++;
            $display("FAIL frame_count_wrap: got wrap %b fc %0d required 1 44", wrap_seen, s_fc);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        test_reset();
        test_line_timing();
        test_mid_reset();
        test_small_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
